freq_meter: RTL and testbench

Gated-window frequency meter: counts rising edges of an asynchronous input signal over a fixed window of `clkin` cycles and reports the count. It is the measuring end of the divided-clock path. It checks the divided clocks that feed the VGA and display logic, and its result is shown on the seven-segment readout. One `clkin` domain; `sig_in` is synchronised internally.

---
 rtl/freq_meter_pkg.sv | 25 ++
 rtl/sync_edge.sv | 35 +++
 rtl/freq_meter.sv | 157 +++++++++++++++
 tb/tb_freq_meter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
// Shared definitions for the gated-window frequency meter:
//   - state_t          : measurement FSM states (IDLE, GATE)
//   - SYS_FREQ_HZ      : nominal clkin frequency
//   - DEF_GATE_CYCLES  : default window length (1 s at SYS_FREQ_HZ)
//   - sat_inc()        : increment that sticks at the all-ones value of a
//                        given width (widths up to 64 bits)
package freq_meter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   localparam int unsigned SYS_FREQ_HZ     = 50000000;
   localparam int unsigned DEF_GATE_CYCLES = SYS_FREQ_HZ;

   // Saturating increment of the low w bits of v.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      logic [63:0] maxv;
      maxv = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (v >= maxv) ? maxv : (v + 64'd1);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Two-flop synchroniser followed by a rising-edge detector for one
// asynchronous input.
// Ports:
//   clkin : system clock
//   rst   : asynchronous active-high reset
//   din   : asynchronous input
//   rise  : one-cycle pulse, high in the clkin cycle after the
//           synchronised level goes from 0 to 1
module sync_edge (
   input  logic clkin,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
// Gated-window frequency meter. Counts rising edges of sig_in over
// windows of GATE_CYCLES clkin cycles, back to back, while en is high.
// Optional feature macro: FREQ_METER_PERIOD_EN adds a period measurement
// (clkin cycles between consecutive sig_in rising edges).
// Ports:
//   clkin        : system clock
//   rst          : asynchronous active-high reset
//   en           : measure continuously while high; low aborts a window
//   sig_in       : signal under measurement (asynchronous)
//   freq         : edge count of the last completed window
//   valid        : one-cycle pulse when freq/ovf update
//   ovf          : last completed window saturated the counter
//   busy         : window in progress (FSM is in GATE); this is the full
//                  FSM state
//   period       : (FREQ_METER_PERIOD_EN) last measured edge-to-edge period
//   period_valid : (FREQ_METER_PERIOD_EN) one-cycle pulse when period updates
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             valid,
   output logic             ovf,
   output logic             busy
`ifdef FREQ_METER_PERIOD_EN
   ,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
`endif
);

   localparam int unsigned      GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state;
   state_t           state_nx;
   logic             win_clear;
   logic             win_end;
   logic             sig_edge;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edge_cnt_nx;
   logic             edge_at_max;
   logic             sat;

   sync_edge u_sync_edge (
      .clkin (clkin),
      .rst   (rst),
      .din   (sig_in),
      .rise  (sig_edge)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // An en fall takes priority over a window end in the same cycle, so a
   // window that ends as en drops is discarded.
   always_comb begin
      state_nx  = state;
      win_clear = 1'b0;
      win_end   = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               state_nx  = GATE;
               win_clear = 1'b1;
            end
         end
         GATE: begin
            if (!en)                        state_nx = IDLE;
            else if (gate_cnt == GATE_LAST) win_end  = 1'b1;
         end
      endcase
   end

   assign busy = (state == GATE);

   // ---------------- window datapath ----------------
   // Edge arriving while the counter is already full is what marks the
   // window as saturated.
   assign edge_at_max = sig_edge && (edge_cnt == CNT_MAX);
   assign edge_cnt_nx = sig_edge ? CNT_W'(sat_inc(64'(edge_cnt), CNT_W)) : edge_cnt;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
         freq     <= '0;
         ovf      <= 1'b0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (win_clear) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
         end else if (win_end) begin
            // The edge of the final window cycle still belongs to this window.
            freq     <= edge_cnt_nx;
            ovf      <= sat | edge_at_max;
            valid    <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
         end else if (state == GATE && en) begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_cnt_nx;
            sat      <= sat | edge_at_max;
         end
      end
   end

`ifdef FREQ_METER_PERIOD_EN
   // ---------------- period measurement ----------------
   // per_cnt restarts at 1 on each edge, so at the next edge it holds the
   // number of clkin cycles between the two edges. armed is cleared while
   // en is low so the first edge after en rises only starts the count.
   logic [CNT_W-1:0] per_cnt;
   logic             armed;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         per_cnt      <= '0;
         armed        <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (sig_edge) per_cnt <= CNT_W'(1);
         else          per_cnt <= CNT_W'(sat_inc(64'(per_cnt), CNT_W));

         if (!en) begin
            armed <= 1'b0;
         end else if (sig_edge) begin
            armed <= 1'b1;
            if (armed) begin
               period       <= per_cnt;
               period_valid <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
// Directed bench for freq_meter with GATE_CYCLES=100 and CNT_W=4, so both
// normal counts and counter saturation fit in one instance. sig_in comes
// from a pattern generator (high phase, low phase, or a fixed level).
module tb_freq_meter;

   localparam int unsigned G = 100;
   localparam int unsigned W = 4;

   logic         clkin = 1'b0;
   logic         rst;
   logic         en;
   logic         sig_in = 1'b0;
   logic [W-1:0] freq;
   logic         valid;
   logic         ovf;
   logic         busy;
`ifdef FREQ_METER_PERIOD_EN
   logic [W-1:0] period;
   logic         period_valid;
`endif

   int   n_checks = 0;
   int   n_errors = 0;

   // pattern generator controls
   int   g_hi = 5;
   int   g_lo = 5;
   int   g_ph = 0;
   bit   g_run = 1'b0;
   logic g_level = 1'b0;

   typedef struct {
      string name;
      int    hi;
      int    lo;
      bit    run;
      logic  level;
      int    exp_freq;
      logic  exp_ovf;
   } vec_t;

   vec_t vecs[9];

   // ---------------- clock ----------------
   always #5 clkin = ~clkin;

   // ---------------- DUT ----------------
   freq_meter #(
      .GATE_CYCLES (G),
      .CNT_W       (W)
   ) dut (
      .clkin        (clkin),
      .rst          (rst),
      .en           (en),
      .sig_in       (sig_in),
      .freq         (freq),
      .valid        (valid),
      .ovf          (ovf),
      .busy         (busy)
`ifdef FREQ_METER_PERIOD_EN
      ,
      .period       (period),
      .period_valid (period_valid)
`endif
   );

   // ---------------- sig_in generator (drives on falling edges) ----------------
   initial begin
      forever begin
         @(negedge clkin);
         if (!g_run) begin
            sig_in = g_level;
            g_ph   = 0;
         end else begin
            sig_in = (g_ph < g_hi) ? 1'b1 : 1'b0;
            g_ph   = g_ph + 1;
            if (g_ph >= g_hi + g_lo) g_ph = 0;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Wait for the next valid pulse; cyc = rising edges waited, sampled 1ns after.
   task automatic wait_valid(input string name, input int budget, output int cyc);
      cyc = 0;
      do begin
         @(posedge clkin);
         #1;
         cyc++;
      end while (!valid && cyc < budget);
      if (!valid) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout actual=no_valid required=valid within %0d cycles", name, budget);
      end
   endtask

`ifdef FREQ_METER_PERIOD_EN
   task automatic wait_pv(input string name, input int budget, output int cyc);
      cyc = 0;
      do begin
         @(posedge clkin);
         #1;
         cyc++;
      end while (!period_valid && cyc < budget);
      if (!period_valid) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout actual=no_period_valid required=pulse within %0d cycles", name, budget);
      end
   endtask
`endif

   // ---------------- test sequence ----------------
   initial begin
      int c;
      int fa;
      int fb;
      int pulses;

      //         name          hi  lo run lvl  freq ovf
      vecs[0] = '{"p10",        5,  5, 1, 1'b0, 10, 1'b0};
      vecs[1] = '{"p4_sat",     2,  2, 1, 1'b0, 15, 1'b1};
      vecs[2] = '{"p10_again",  5,  5, 1, 1'b0, 10, 1'b0};
      vecs[3] = '{"p20",       10, 10, 1, 1'b0,  5, 1'b0};
      vecs[4] = '{"p50",       25, 25, 1, 1'b0,  2, 1'b0};
      vecs[5] = '{"p5_sat",     2,  3, 1, 1'b0, 15, 1'b1};
      vecs[6] = '{"p25",       12, 13, 1, 1'b0,  4, 1'b0};
      vecs[7] = '{"stuck_hi",   1,  1, 0, 1'b1,  0, 1'b0};
      vecs[8] = '{"stuck_lo",   1,  1, 0, 1'b0,  0, 1'b0};

      // reset
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(posedge clkin);
      #1;
      chk("rst_freq", 32'(freq), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_busy", 32'(busy), 0);
`ifdef FREQ_METER_PERIOD_EN
      chk("rst_period", 32'(period), 0);
      chk("rst_period_valid", 32'(period_valid), 0);
`endif
      @(negedge clkin);
      rst = 1'b0;

      // edges while idle must not start anything
      g_hi  = 5;
      g_lo  = 5;
      g_run = 1'b1;
      pulses = 0;
      repeat (30) begin
         @(posedge clkin);
         #1;
         if (valid || busy) pulses++;
      end
      chk("idle_quiet", 32'(pulses), 0);

      // first window: busy one edge after en, valid 100 edges later
      @(negedge clkin);
      en = 1'b1;
      @(posedge clkin);
      #1;
      chk("busy_after_en", 32'(busy), 1);
      wait_valid("first_valid", 300, c);
      chk("first_valid_lat", 32'(c), 100);
      chk("first_freq", 32'(freq), 10);
      chk("first_ovf", 32'(ovf), 0);
      @(posedge clkin);
      #1;
      chk("valid_one_cycle", 32'(valid), 0);

      // table: change pattern, discard the mixed window, check the next
      for (int i = 0; i < 9; i++) begin
         g_hi    = vecs[i].hi;
         g_lo    = vecs[i].lo;
         g_level = vecs[i].level;
         g_run   = vecs[i].run;
         wait_valid({vecs[i].name, "_settle"}, 300, c);
         wait_valid(vecs[i].name, 300, c);
         chk({vecs[i].name, "_spacing"}, 32'(c), G);
         chk({vecs[i].name, "_freq"}, 32'(freq), 32'(vecs[i].exp_freq));
         chk({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].exp_ovf));
      end

      // abort mid-window: freq/ovf keep old values, no valid
      g_hi  = 5;
      g_lo  = 5;
      g_run = 1'b1;
      wait_valid("abort_settle", 300, c);
      wait_valid("abort_pre", 300, c);
      chk("abort_pre_freq", 32'(freq), 10);
      g_hi = 2;
      g_lo = 2;
      repeat (50) @(posedge clkin);
      #1;
      chk("hold_mid_window", 32'(freq), 10);
      @(negedge clkin);
      en = 1'b0;
      @(posedge clkin);
      #1;
      chk("abort_busy", 32'(busy), 0);
      pulses = 0;
      repeat (150) begin
         @(posedge clkin);
         #1;
         if (valid) pulses++;
      end
      chk("abort_no_valid", 32'(pulses), 0);
      chk("abort_freq_kept", 32'(freq), 10);
      chk("abort_ovf_kept", 32'(ovf), 0);
      @(negedge clkin);
      en = 1'b1;
      wait_valid("reraise", 300, c);
      chk("reraise_lat", 32'(c), 101);
      chk("reraise_freq", 32'(freq), 15);
      chk("reraise_ovf", 32'(ovf), 1);

      // asynchronous reset mid-window
      repeat (30) @(posedge clkin);
      #2;
      rst = 1'b1;
      #1;
      chk("amid_rst_freq", 32'(freq), 0);
      chk("amid_rst_ovf", 32'(ovf), 0);
      chk("amid_rst_busy", 32'(busy), 0);
      chk("amid_rst_valid", 32'(valid), 0);
      g_hi = 5;
      g_lo = 5;
      repeat (5) @(negedge clkin);
      rst = 1'b0;
      wait_valid("post_rst", 300, c);
      chk("post_rst_lat", 32'(c), 101);

      // edge in the final window cycle: counted exactly once
      g_run   = 1'b0;
      g_level = 1'b0;
      wait_valid("last_settle", 300, c);
      wait_valid("last_pre", 300, c);
      chk("last_pre_freq", 32'(freq), 0);
      repeat (99) @(posedge clkin);
      #1;
      g_level = 1'b1;
      wait_valid("last_a", 300, c);
      chk("last_a_lat", 32'(c), 1);
      fa = 32'(freq);
      wait_valid("last_b", 300, c);
      fb = 32'(freq);
      chk("last_edge_once", 32'(fa + fb), 1);
      wait_valid("last_c", 300, c);
      chk("last_after_freq", 32'(freq), 0);

`ifdef FREQ_METER_PERIOD_EN
      // period: first edge only arms, then period=7 on every edge
      @(negedge clkin);
      en      = 1'b0;
      g_run   = 1'b0;
      g_level = 1'b0;
      repeat (10) @(posedge clkin);
      @(negedge clkin);
      en = 1'b1;
      repeat (5) @(posedge clkin);
      #1;
      g_hi  = 3;
      g_lo  = 4;
      g_run = 1'b1;
      wait_pv("period_first", 40, c);
      chk("period_first_lat", 32'(c), 10);
      chk("period_first_val", 32'(period), 7);
      for (int i = 0; i < 3; i++) begin
         wait_pv("period_next", 40, c);
         chk("period_spacing", 32'(c), 7);
         chk("period_val", 32'(period), 7);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
